// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
//   Streams the completed bank of a double-banked pixel BRAM to the Ethernet
//   packet transmitter. There is one packet per row: a 4-byte header
//   (frame_id, row[15:8], row[7:0], read bank) followed by ACTIVE_COLS RGB
//   triplets. A frame-start pulse swaps the write/read banks. While a frame
//   is being sent, one further frame-start is held as pending. Any more are
//   counted as dropped.
//
// Ports
//   clk125MHz       sole clock
//   resetn          synchronous active-low reset
//   start_frame     one-cycle frame-start pulse (already in clk125MHz domain)
//   wr_bank         bank the pixel writer fills
//   rd_en/rd_addr   BRAM read strobe and word address
//   rd_data         {r,g,b}, valid the cycle after rd_en
//   pkt_req/pkt_ack packet request and one-cycle grant
//   tx_valid/tx_data/tx_last  byte stream to the transmitter
//   frame_id        id of the frame being sent
//   busy            high whenever the scheduler is not idle
//   dropped_frames  saturating count of discarded frame-start pulses
module frame_tx_scheduler #(
  parameter int unsigned ACTIVE_COLS = 320,
  parameter int unsigned ACTIVE_ROWS = 180,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned GAP_CYCLES  = 12
) (
  input  logic              clk125MHz,
  input  logic              resetn,
  input  logic              start_frame,
  output logic              wr_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              pkt_req,
  input  logic              pkt_ack,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  output logic [7:0]        frame_id,
  output logic              busy,
  output logic [7:0]        dropped_frames
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HDR,
    S_PIX,
    S_GAP
  } state_t;

  localparam logic [ADDR_W-1:0] BANK_WORDS = ADDR_W'(ACTIVE_COLS * ACTIVE_ROWS);
  localparam logic [ADDR_W-1:0] COLS_W     = ADDR_W'(ACTIVE_COLS);
  localparam logic [9:0]        LAST_COL   = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0]        LAST_ROW   = 10'(ACTIVE_ROWS - 1);
  localparam int unsigned       GAP_W      = $clog2(GAP_CYCLES) + 1;
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  logic              pending;
  logic              started;
  logic              rd_bank;
  logic [9:0]        row;
  logic [9:0]        col;
  logic [1:0]        phase;
  logic [1:0]        hdr_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        hdr_byte;
  logic [23:0]       pix_hold;
  logic              rd_en_d;

  logic [15:0]       row16;
  logic [ADDR_W-1:0] row_addr;
  logic [23:0]       pix_src;
  logic [7:0]        pix_byte;

  assign row16    = 16'(row);
  assign row_addr = (rd_bank ? BANK_WORDS : '0) + ADDR_W'(row) * COLS_W;

  // Pixel 0 is read on the last header byte, so its r byte has to come
  // straight from rd_data. Every later pixel is read two cycles ahead of its
  // r byte and is served from the holding register.
  always_comb begin
    pix_src = pix_hold;
    if (col == '0 && phase == 2'd0) pix_src = rd_data;
    unique case (phase)
      2'd0:    pix_byte = pix_src[23:16];
      2'd1:    pix_byte = pix_src[15:8];
      default: pix_byte = pix_src[7:0];
    endcase
    tx_data = (state == S_PIX) ? pix_byte : hdr_byte;
  end

  always_ff @(posedge clk125MHz) begin
    if (!resetn) begin
      state          <= S_IDLE;
      pending        <= 1'b0;
      started        <= 1'b0;
      rd_bank        <= 1'b0;
      row            <= '0;
      col            <= '0;
      phase          <= '0;
      hdr_idx        <= '0;
      gap_cnt        <= '0;
      hdr_byte       <= '0;
      pix_hold       <= '0;
      rd_en_d        <= 1'b0;
      wr_bank        <= 1'b0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      pkt_req        <= 1'b0;
      tx_valid       <= 1'b0;
      tx_last        <= 1'b0;
      frame_id       <= '0;
      busy           <= 1'b0;
      dropped_frames <= '0;
    end else begin
      rd_en   <= 1'b0;
      rd_en_d <= rd_en;
      if (rd_en_d) pix_hold <= rd_data;

      // Extra frame-starts while the frame is in progress: the first one is
      // remembered, the rest are counted and discarded.
      if (state != S_IDLE && start_frame) begin
        if (!pending) begin
          pending <= 1'b1;
        end else if (dropped_frames != 8'hFF) begin
          dropped_frames <= dropped_frames + 8'd1;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (start_frame || pending) begin
            wr_bank <= ~wr_bank;
            rd_bank <= wr_bank;
            row     <= '0;
            pending <= 1'b0;
            started <= 1'b1;
            if (started) frame_id <= frame_id + 8'd1;
            pkt_req <= 1'b1;
            busy    <= 1'b1;
            state   <= S_REQ;
          end
        end

        S_REQ: begin
          if (pkt_ack) begin
            pkt_req  <= 1'b0;
            tx_valid <= 1'b1;
            hdr_byte <= frame_id;
            hdr_idx  <= '0;
            state    <= S_HDR;
          end
        end

        S_HDR: begin
          hdr_idx <= hdr_idx + 2'd1;
          unique case (hdr_idx)
            2'd0: hdr_byte <= row16[15:8];
            2'd1: hdr_byte <= row16[7:0];
            2'd2: begin
              hdr_byte <= {7'b0, rd_bank};
              rd_en    <= 1'b1;
              rd_addr  <= row_addr;
            end
            default: begin
              hdr_byte <= '0;
              col      <= '0;
              phase    <= '0;
              state    <= S_PIX;
            end
          endcase
        end

        S_PIX: begin
          unique case (phase)
            2'd0: begin
              phase <= 2'd1;
              // Next pixel is read during this pixel's g byte.
              if (col != LAST_COL) begin
                rd_en   <= 1'b1;
                rd_addr <= rd_addr + ADDR_W'(1);
              end
            end
            2'd1: begin
              phase <= 2'd2;
              if (col == LAST_COL) tx_last <= 1'b1;
            end
            default: begin
              phase <= 2'd0;
              if (col == LAST_COL) begin
                col      <= '0;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                gap_cnt  <= '0;
                state    <= S_GAP;
              end else begin
                col <= col + 10'd1;
              end
            end
          endcase
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (row < LAST_ROW) begin
              row     <= row + 10'd1;
              pkt_req <= 1'b1;
              state   <= S_REQ;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_tx_scheduler.md
Name: frame_tx_scheduler

Overview:
- Sits in the clk125MHz domain between the double-banked pixel BRAM, which is filled at pclk rate, and the Ethernet packet transmitter.
- On each frame-start pulse it swaps the BRAM write/read banks.
- It then streams the completed bank as one packet per row: a 4-byte header followed by RGB payload bytes.
- It owns BRAM read addressing, the packet request/ack handshake, inter-packet gap timing and frame-overrun accounting.

Parameters:
ACTIVE_COLS, 320, pixels per row
ACTIVE_ROWS, 180, rows per frame
ADDR_W, 17, BRAM word address width; must hold 2*ACTIVE_COLS*ACTIVE_ROWS
GAP_CYCLES, 12, idle cycles between packets, minimum 1

Ports:
clk125MHz  in  1  sole clock
resetn  in  1  synchronous active-low reset
start_frame  in  1  one-cycle pulse, already synchronised to clk125MHz
wr_bank  out  1  bank the pixel writer fills; writer adds wr_bank*ACTIVE_COLS*ACTIVE_ROWS to its address
rd_en  out  1  BRAM read strobe
rd_addr  out  ADDR_W  BRAM read word address
rd_data  in  24  {r,g,b}; valid exactly 1 cycle after rd_en
pkt_req  out  1  packet request to transmitter
pkt_ack  in  1  one-cycle grant from transmitter
tx_valid  out  1  byte strobe
tx_data  out  8  byte
tx_last  out  1  final byte of packet
frame_id  out  8  id of frame being sent
busy  out  1  high in any state other than IDLE
dropped_frames  out  8  saturating count of discarded start_frame pulses

Behaviour:
- Reset (resetn low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: wr_bank, rd_en, rd_addr, pkt_req, tx_*, frame_id, busy, dropped_frames.
  - Internal pending flag, row, col and byte phase are cleared.
  - Reset mid-packet aborts immediately. No tx_last is emitted.
- States: IDLE, REQ, HDR, PIX, GAP.
- IDLE:
  - On start_frame, or when pending is set: toggle wr_bank, set read bank = old wr_bank, row=0, clear pending, go to REQ.
  - frame_id increments (mod 256) on every bank swap except the first after reset, which sends frame_id 0.
- REQ:
  - pkt_req=1 until the cycle pkt_ack is sampled high, then go to HDR.
  - pkt_ack outside REQ is ignored.
- HDR: 4 cycles, tx_valid=1. Bytes in order:
  - frame_id
  - row[15:8]
  - row[7:0]
  - {7'b0, read bank}
- PIX: ACTIVE_COLS*3 cycles, tx_valid=1 continuously.
  - Bytes per pixel in order: r=rd_data[23:16], g=[15:8], b=[7:0].
  - No bubbles are permitted.
  - rd_addr = bank*ACTIVE_COLS*ACTIVE_ROWS + row*ACTIVE_COLS + col.
  - Pixel 0 is read (rd_en=1) on header byte 3.
  - Pixel c+1 is read on the g-byte cycle of pixel c.
  - rd_data is captured into a holding register the cycle after rd_en.
  - rd_en is high exactly ACTIVE_COLS cycles per packet. No read is issued past the last column.
  - tx_last=1 on the b byte of the last column. Then go to GAP.
- GAP:
  - GAP_CYCLES idle cycles, outputs low.
  - Then if row < ACTIVE_ROWS-1: row++ and go to REQ.
  - Otherwise go to IDLE.
- Packet length is fixed at 4 + 3*ACTIVE_COLS bytes (964 by default).
- start_frame while busy:
  - If pending=0: set pending. The current frame completes, then the new frame starts from IDLE on the next cycle.
  - If pending=1: dropped_frames++ (saturates at 255). No bank swap occurs.
  - wr_bank never toggles while busy, so the writer never overwrites the bank being read.
- start_frame in the same cycle as the GAP→IDLE transition of the last row: treated as busy (sets pending), then served from IDLE.
- Width rules:
  - row*ACTIVE_COLS is computed at ADDR_W bits.
  - row and col are 10-bit counters that wrap only via the explicit terminal compares above.

Test Plan:
1. Reset, one start_frame, pkt_ack 3 cycles after every pkt_req → wr_bank=1, frame_id=0; 180 packets of 964 bytes each. Packet 5 header = 00,00,05,00. First rd_addr of row 5 = 1600; rd_addr of the last pixel of the frame = 57599.
2. BRAM model returns data=address → row 0 payload bytes 00,00,00, 00,00,01, …, last three bytes 00,01,3F. tx_last only on byte 964. Exactly 320 rd_en pulses per packet.
3. Second start_frame after frame 1 ends → wr_bank=0, frame_id=1, header byte3=01, first rd_addr=57600.
4. Two start_frame pulses during row 10 of frame 0 → dropped_frames=1. Frame 1 starts 1 cycle after frame 0's final GAP; wr_bank toggles exactly once.
5. pkt_ack delayed 50 cycles → pkt_req held 50 cycles and tx_valid low throughout; measured gap between tx_last and the next pkt_req = 12 cycles.
6. resetn low during PIX of row 7 → next cycle all outputs 0; a new start_frame produces frame_id 0, wr_bank=1, row 0.
